// File: rtl/map_pkg.sv
// Shared constants and types for the scratch-memory mapping table: lane geometry,
// write-settle timing and the table writer state encoding.
package map_pkg;

  localparam int ENTRIES     = 256;
  localparam int ENTRY_W     = 8;
  localparam int LANE_W      = 32;
  localparam int LANES       = 4;
  localparam int DATA_W      = LANE_W * LANES;
  localparam int ADDR_W      = 16;
  localparam int WT_IDLE     = 2;
  localparam int SC_LINES    = ENTRIES / LANES;

  // Counters are one bit wider than the index range so the terminal count is representable.
  localparam int ENTRY_CNT_W = $clog2(ENTRIES + 1);
  localparam int LINE_CNT_W  = $clog2(SC_LINES + 1);
  localparam int WAIT_W      = $clog2(WT_IDLE + 1);
  localparam int LANE_SEL_W  = $clog2(LANES);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_COLLECT    = 2'd1,
    ST_WRITE_IDLE = 2'd2,
    ST_DONE       = 2'd3
  } wr_state_e;

  function automatic logic [LANE_W-1:0] lane_word(input logic [ENTRY_W-1:0] v);
    return {{(LANE_W - ENTRY_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/sc_lane_packer.sv
// Four-lane line buffer: loads one entry into the selected 32-bit lane and exposes the
// line with the incoming entry already merged, so the last lane can be written directly.
module sc_lane_packer
  import map_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  load,
  input  logic [LANE_SEL_W-1:0] lane_sel,
  input  logic [ENTRY_W-1:0]    din,
  output logic [DATA_W-1:0]     line_merged
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [LANE_SEL_W-1:0] LANE_ID = LANE_SEL_W'(gi);

      logic [LANE_W-1:0] lane_q;
      logic [LANE_W-1:0] lane_d;
      logic              hit;

      assign hit = load && (lane_sel == LANE_ID);

      // Clear wins over load: the lane-3 accept both completes and empties the line.
      always_comb begin
        lane_d = lane_q;
        if (clr) begin
          lane_d = '0;
        end else if (hit) begin
          lane_d = lane_word(din);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          lane_q <= '0;
        end else begin
          lane_q <= lane_d;
        end
      end

      assign line_merged[gi*LANE_W +: LANE_W] = hit ? lane_word(din) : lane_q;
    end
  endgenerate

endmodule

// File: rtl/sc_map_table_writer.sv
// Collects 256 mapped values, packs them four per line and writes scratch lines 0..63,
// then pulses div_sc_mem_wt_done to release the mapping controller.
module sc_map_table_writer
  import map_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [ENTRY_W-1:0] in_data,
  output logic               in_ready,
  output logic [DATA_W-1:0]  sc_mem_wt_data,
  output logic [ADDR_W-1:0]  sc_mem_wt_addr,
  output logic               sc_mem_wt_en,
  output logic               div_sc_mem_wt_done,
  output logic               busy
);

  wr_state_e               state_q, state_d;
  logic [ENTRY_CNT_W-1:0]  entry_cnt_q, entry_cnt_d;
  logic [LINE_CNT_W-1:0]   line_cnt_q, line_cnt_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]       wt_data_q, wt_data_d;
  logic [ADDR_W-1:0]       wt_addr_q, wt_addr_d;
  logic                    wt_en_q, wt_en_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic                    accept;
  logic                    last_lane;
  logic                    pk_clr;
  logic [DATA_W-1:0]       pk_line;

  assign in_ready  = (state_q == ST_COLLECT);
  assign accept    = in_valid && in_ready;
  assign last_lane = (entry_cnt_q[LANE_SEL_W-1:0] == LANE_SEL_W'(LANES - 1));

  sc_lane_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clr         (pk_clr),
    .load        (accept),
    .lane_sel    (entry_cnt_q[LANE_SEL_W-1:0]),
    .din         (in_data),
    .line_merged (pk_line)
  );

  always_comb begin
    state_d     = state_q;
    entry_cnt_d = entry_cnt_q;
    line_cnt_d  = line_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    wt_data_d   = wt_data_q;
    wt_addr_d   = wt_addr_q;
    wt_en_d     = 1'b0;
    done_d      = 1'b0;
    busy_d      = busy_q;
    pk_clr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_COLLECT;
          busy_d      = 1'b1;
          entry_cnt_d = '0;
          line_cnt_d  = '0;
          wait_cnt_d  = '0;
          pk_clr      = 1'b1;
        end
      end

      ST_COLLECT: begin
        if (accept) begin
          entry_cnt_d = entry_cnt_q + 1'b1;
          if (last_lane) begin
            wt_data_d  = pk_line;
            wt_addr_d  = {{(ADDR_W - LINE_CNT_W){1'b0}}, line_cnt_q};
            wt_en_d    = 1'b1;
            line_cnt_d = line_cnt_q + 1'b1;
            wait_cnt_d = '0;
            pk_clr     = 1'b1;
            state_d    = ST_WRITE_IDLE;
          end
        end
      end

      // Write cycle plus WT_IDLE settle cycles; address and data hold throughout.
      ST_WRITE_IDLE: begin
        if (wait_cnt_q == WAIT_W'(WT_IDLE)) begin
          if (line_cnt_q == LINE_CNT_W'(SC_LINES)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      entry_cnt_q <= '0;
      line_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      wt_data_q   <= '0;
      wt_addr_q   <= '0;
      wt_en_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_cnt_q <= entry_cnt_d;
      line_cnt_q  <= line_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      wt_data_q   <= wt_data_d;
      wt_addr_q   <= wt_addr_d;
      wt_en_q     <= wt_en_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign sc_mem_wt_data     = wt_data_q;
  assign sc_mem_wt_addr     = wt_addr_q;
  assign sc_mem_wt_en       = wt_en_q;
  assign div_sc_mem_wt_done = done_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_sc_map_table_writer.sv
// Scoreboard bench for sc_map_table_writer: expected lines are queued as entries are
// accepted and compared against writes captured from the scratch port.
module tb_sc_map_table_writer;
  import map_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               in_valid;
  logic [ENTRY_W-1:0] in_data;
  logic               in_ready;
  logic [DATA_W-1:0]  sc_mem_wt_data;
  logic [ADDR_W-1:0]  sc_mem_wt_addr;
  logic               sc_mem_wt_en;
  logic               div_sc_mem_wt_done;
  logic               busy;

  sc_map_table_writer dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_ready           (in_ready),
    .sc_mem_wt_data     (sc_mem_wt_data),
    .sc_mem_wt_addr     (sc_mem_wt_addr),
    .sc_mem_wt_en       (sc_mem_wt_en),
    .div_sc_mem_wt_done (div_sc_mem_wt_done),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [ENTRY_W-1:0] vals [ENTRIES];
  logic [ADDR_W-1:0]  exp_addr_q [$];
  logic [DATA_W-1:0]  exp_data_q [$];
  logic [ADDR_W-1:0]  cap_addr_q [$];
  logic [DATA_W-1:0]  cap_data_q [$];
  int                 cap_cyc_q  [$];

  int   done_cnt = 0;
  int   done_cyc = 0;
  int   acc_cnt  = 0;
  int   rdy_viol = 0;
  int   ro_win   = 0;
  logic busy_at_done    = 1'b0;
  logic busy_after_done = 1'b0;
  logic prev_done       = 1'b0;

  // Passive monitor on the falling edge: records writes, done pulses, accepts and
  // any in_ready seen during the write/settle window.
  always @(negedge clk) begin
    if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    if (sc_mem_wt_en) begin
      cap_addr_q.push_back(sc_mem_wt_addr);
      cap_data_q.push_back(sc_mem_wt_data);
      cap_cyc_q.push_back(cyc);
      if (in_ready) rdy_viol <= rdy_viol + 1;
      ro_win <= WT_IDLE;
    end else if (ro_win > 0) begin
      if (in_ready) rdy_viol <= rdy_viol + 1;
      ro_win <= ro_win - 1;
    end
    if (div_sc_mem_wt_done) begin
      done_cnt     <= done_cnt + 1;
      done_cyc     <= cyc;
      busy_at_done <= busy;
    end
    prev_done <= div_sc_mem_wt_done;
    if (prev_done) busy_after_done <= busy;
  end

  task automatic do_start();
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Presents vals[0..n-1]; queues the expected line whenever a lane-3 entry is accepted.
  task automatic feed(input int n, input bit bubbles, input int glitch_idx);
    int idx = 0;
    int guard = 0;
    bit acc;
    logic [DATA_W-1:0] line;
    while (idx < n) begin
      in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = vals[idx];
      start    = (idx == glitch_idx);
      acc      = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        if (idx % 4 == 3) begin
          for (int l = 0; l < 4; l++) line[l*LANE_W +: LANE_W] = {24'h0, vals[idx-3+l]};
          exp_addr_q.push_back(ADDR_W'(idx / 4));
          exp_data_q.push_back(line);
        end
        idx++;
      end
      guard++;
      if (guard > n * 20 + 50) begin
        tests_run++;
        tests_failed++;
        $display("FAIL feed_timeout accepted %0d required %0d", idx, n);
        break;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({in_ready, sc_mem_wt_en, div_sc_mem_wt_done, busy} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl got %b required 0000", {in_ready, sc_mem_wt_en, div_sc_mem_wt_done, busy});
    end
    tests_run++;
    if (sc_mem_wt_addr !== '0 || sc_mem_wt_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus addr %h data %h required 0", sc_mem_wt_addr, sc_mem_wt_data);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    $display("[TB] reset checked");
  endtask

  task automatic test_ramp();
    int done_base = done_cnt;
    int k = 0;
    logic [ADDR_W-1:0] ea, ca;
    logic [DATA_W-1:0] ed, cd;
    int cc;
    for (int i = 0; i < ENTRIES; i++) vals[i] = ENTRY_W'(i);
    do_start();
    feed(ENTRIES, 1'b0, -1);
    repeat (12) @(posedge clk);
    #1;
    tests_run++;
    if (cap_addr_q.size() != exp_addr_q.size() || exp_addr_q.size() != SC_LINES) begin
      tests_failed++;
      $display("FAIL ramp_count got %0d required %0d", cap_addr_q.size(), SC_LINES);
    end
    while (exp_addr_q.size() > 0 && cap_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
      ca = cap_addr_q.pop_front(); cd = cap_data_q.pop_front(); cc = cap_cyc_q.pop_front();
      tests_run++;
      if (ca !== ea || cd !== ed) begin
        tests_failed++;
        $display("FAIL ramp_line %0d got %0d:%h required %0d:%h", k, ca, cd, ea, ed);
      end
      if (k == 0) begin
        tests_run++;
        if (cd !== 128'h00000003_00000002_00000001_00000000) begin
          tests_failed++;
          $display("FAIL ramp_line0 got %h required 00000003000000020000000100000000", cd);
        end
      end
      if (k == SC_LINES - 1) begin
        tests_run++;
        if (cd[127:96] !== 32'h000000FF || ca !== 16'd63) begin
          tests_failed++;
          $display("FAIL ramp_line63 got %0d:%h required 63:000000ff", ca, cd[127:96]);
        end
      end
      k++;
    end
    tests_run++;
    if (done_cnt - done_base != 1) begin
      tests_failed++;
      $display("FAIL ramp_done got %0d required 1", done_cnt - done_base);
    end
    $display("[TB] ramp: %0d lines compared", k);
  endtask

  task automatic test_timing();
    int done_base = done_cnt;
    int n = 0;
    int prev_cc = -100;
    int min_gap = 1000;
    int last_cc = 0;
    logic [ADDR_W-1:0] ea, ca;
    logic [DATA_W-1:0] ed, cd;
    int cc;
    for (int i = 0; i < ENTRIES; i++) vals[i] = ENTRY_W'(i * 7);
    do_start();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL timing_busy_rise got %b required 1", busy);
    end
    feed(ENTRIES, 1'b0, -1);
    repeat (12) @(posedge clk);
    #1;
    while (exp_addr_q.size() > 0 && cap_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
      ca = cap_addr_q.pop_front(); cd = cap_data_q.pop_front(); cc = cap_cyc_q.pop_front();
      tests_run++;
      if (ca !== ea || cd !== ed) begin
        tests_failed++;
        $display("FAIL timing_line %0d got %0d:%h required %0d:%h", n, ca, cd, ea, ed);
      end
      if (cc - prev_cc < min_gap) min_gap = cc - prev_cc;
      prev_cc = cc;
      last_cc = cc;
      n++;
    end
    tests_run++;
    if (n != SC_LINES || cap_addr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL timing_count got %0d required %0d", n + cap_addr_q.size(), SC_LINES);
    end
    tests_run++;
    if (min_gap < 7) begin
      tests_failed++;
      $display("FAIL timing_gap got %0d required >=7", min_gap);
    end
    tests_run++;
    if (done_cnt - done_base != 1 || done_cyc != last_cc + 3) begin
      tests_failed++;
      $display("FAIL timing_done count %0d cycle %0d required 1 at %0d", done_cnt - done_base, done_cyc, last_cc + 3);
    end
    tests_run++;
    if (busy_at_done !== 1'b1 || busy_after_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL timing_busy got %b%b required 10", busy_at_done, busy_after_done);
    end
    $display("[TB] timing: %0d writes, min gap %0d", n, min_gap);
  endtask

  task automatic test_bubbles();
    int done_base = done_cnt;
    int acc_base;
    int viol_base = rdy_viol;
    int n = 0;
    logic [ADDR_W-1:0] ea, ca;
    logic [DATA_W-1:0] ed, cd;
    int cc;
    for (int i = 0; i < ENTRIES; i++) vals[i] = ENTRY_W'(255 - i);
    do_start();
    acc_base = acc_cnt;
    feed(ENTRIES, 1'b1, -1);
    repeat (12) @(posedge clk);
    #1;
    tests_run++;
    if (cap_addr_q.size() != SC_LINES || exp_addr_q.size() != SC_LINES) begin
      tests_failed++;
      $display("FAIL bubble_count got %0d required %0d", cap_addr_q.size(), SC_LINES);
    end
    while (exp_addr_q.size() > 0 && cap_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
      ca = cap_addr_q.pop_front(); cd = cap_data_q.pop_front(); cc = cap_cyc_q.pop_front();
      tests_run++;
      if (ca !== ea || cd !== ed) begin
        tests_failed++;
        $display("FAIL bubble_line %0d got %0d:%h required %0d:%h", n, ca, cd, ea, ed);
      end
      n++;
    end
    tests_run++;
    if (acc_cnt - acc_base != ENTRIES) begin
      tests_failed++;
      $display("FAIL bubble_accepts got %0d required %0d", acc_cnt - acc_base, ENTRIES);
    end
    tests_run++;
    if (rdy_viol != viol_base) begin
      tests_failed++;
      $display("FAIL bubble_ready_window got %0d required %0d", rdy_viol, viol_base);
    end
    tests_run++;
    if (done_cnt - done_base != 1) begin
      tests_failed++;
      $display("FAIL bubble_done got %0d required 1", done_cnt - done_base);
    end
    $display("[TB] bubbles: %0d lines compared", n);
  endtask

  task automatic test_start_ignored();
    int done_base = done_cnt;
    int n = 0;
    logic [ADDR_W-1:0] ea, ca;
    logic [DATA_W-1:0] ed, cd;
    int cc;
    for (int i = 0; i < ENTRIES; i++) vals[i] = ENTRY_W'($urandom);
    do_start();
    feed(ENTRIES, 1'b0, 40);
    for (int k = 0; k < 20 && !div_sc_mem_wt_done; k++) begin
      @(posedge clk); #1;
    end
    tests_run++;
    if (div_sc_mem_wt_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_done_wait got %b required 1", div_sc_mem_wt_done);
    end
    start = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_after_done busy %b ready %b required 00", busy, in_ready);
    end
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_accept busy got %b required 1", busy);
    end
    feed(ENTRIES, 1'b0, -1);
    repeat (12) @(posedge clk);
    #1;
    tests_run++;
    if (cap_addr_q.size() != 2 * SC_LINES || exp_addr_q.size() != 2 * SC_LINES) begin
      tests_failed++;
      $display("FAIL restart_count got %0d required %0d", cap_addr_q.size(), 2 * SC_LINES);
    end
    while (exp_addr_q.size() > 0 && cap_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
      ca = cap_addr_q.pop_front(); cd = cap_data_q.pop_front(); cc = cap_cyc_q.pop_front();
      tests_run++;
      if (ca !== ea || cd !== ed) begin
        tests_failed++;
        $display("FAIL restart_line %0d got %0d:%h required %0d:%h", n, ca, cd, ea, ed);
      end
      n++;
    end
    tests_run++;
    if (done_cnt - done_base != 2) begin
      tests_failed++;
      $display("FAIL restart_done got %0d required 2", done_cnt - done_base);
    end
    $display("[TB] start ignored/restart: %0d lines compared", n);
  endtask

  task automatic test_reset_mid();
    int done_base = done_cnt;
    int n = 0;
    logic [ADDR_W-1:0] ea, ca;
    logic [DATA_W-1:0] ed, cd;
    int cc;
    for (int i = 0; i < ENTRIES; i++) vals[i] = ENTRY_W'(i * 3 + 5);
    do_start();
    feed(41, 1'b0, -1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if ({in_ready, sc_mem_wt_en, div_sc_mem_wt_done, busy} !== 4'b0000 ||
        sc_mem_wt_addr !== '0 || sc_mem_wt_data !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs ctrl %b addr %h data %h required all 0",
               {in_ready, sc_mem_wt_en, div_sc_mem_wt_done, busy}, sc_mem_wt_addr, sc_mem_wt_data);
    end
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (cap_addr_q.size() != 10 || exp_addr_q.size() != 10 || done_cnt != done_base) begin
      tests_failed++;
      $display("FAIL midreset_abandon writes %0d done %0d required 10 and 0", cap_addr_q.size(), done_cnt - done_base);
    end
    do_start();
    feed(ENTRIES, 1'b0, -1);
    repeat (12) @(posedge clk);
    #1;
    while (exp_addr_q.size() > 0 && cap_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
      ca = cap_addr_q.pop_front(); cd = cap_data_q.pop_front(); cc = cap_cyc_q.pop_front();
      tests_run++;
      if (ca !== ea || cd !== ed) begin
        tests_failed++;
        $display("FAIL midreset_line %0d got %0d:%h required %0d:%h", n, ca, cd, ea, ed);
      end
      n++;
    end
    tests_run++;
    if (n != 10 + SC_LINES || done_cnt - done_base != 1) begin
      tests_failed++;
      $display("FAIL midreset_rerun lines %0d done %0d required %0d and 1", n, done_cnt - done_base, 10 + SC_LINES);
    end
    $display("[TB] mid-run reset: %0d lines compared", n);
  endtask

  task automatic test_start_with_valid();
    int done_base = done_cnt;
    int n = 0;
    logic [ADDR_W-1:0] ea, ca;
    logic [DATA_W-1:0] ed, cd;
    int cc;
    for (int i = 0; i < ENTRIES; i++) vals[i] = ENTRY_W'(i) ^ 8'h5A;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    @(posedge clk); #1;
    start = 1'b0;
    feed(ENTRIES, 1'b0, -1);
    repeat (12) @(posedge clk);
    #1;
    while (exp_addr_q.size() > 0 && cap_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
      ca = cap_addr_q.pop_front(); cd = cap_data_q.pop_front(); cc = cap_cyc_q.pop_front();
      tests_run++;
      if (ca !== ea || cd !== ed) begin
        tests_failed++;
        $display("FAIL startvalid_line %0d got %0d:%h required %0d:%h", n, ca, cd, ea, ed);
      end
      if (n == 0) begin
        tests_run++;
        if (cd[7:0] !== 8'h5A) begin
          tests_failed++;
          $display("FAIL startvalid_lane0 got %h required 5a", cd[7:0]);
        end
      end
      n++;
    end
    tests_run++;
    if (n != SC_LINES || cap_addr_q.size() != 0 || done_cnt - done_base != 1) begin
      tests_failed++;
      $display("FAIL startvalid_count lines %0d done %0d required %0d and 1", n, done_cnt - done_base, SC_LINES);
    end
    $display("[TB] start with valid: %0d lines compared", n);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_timing();
    test_bubbles();
    test_start_ignored();
    test_reset_mid();
    test_start_with_valid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
